seq_divider: RTL and testbench

- Iterative radix-2 restoring divider. It is the inverse operation of the team's combinational `len`×`len` multiplier.
- Divides a 2*len-bit dividend (product-width) by a len-bit divisor, one quotient bit per clock.
- Sits downstream of the multiplier datapath for normalisation and ratio computation.
- Start/done handshake. Result held until the next start.

---
 rtl/seq_divider_if.sv | 16 +
 rtl/seq_divider.sv | 109 ++++++++++
 tb/tb_seq_divider.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus for the sequential divider.
interface seq_divider_if #(
  parameter int len = 8
);
  logic             start;
  logic [2*len-1:0] A;
  logic [len-1:0]   B;
  logic             busy;
  logic             done;
  logic [len-1:0]   Q;
  logic [len-1:0]   R;
  logic             ovf;

  modport master (output start, A, B, input busy, done, Q, R, ovf);
  modport slave  (input start, A, B, output busy, done, Q, R, ovf);
endinterface

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: 2*len-bit dividend by len-bit divisor,
// one quotient bit per clock, start/done handshake, result held until next completion.
module seq_divider #(
  parameter int len = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_divider_if.slave   bus
);
  localparam int CW = $clog2(len + 1);

  typedef enum logic [1:0] {IDLE, CALC, OVF} state_t;

  state_t          state, state_next;
  // Partial remainder is kept len bits wide: it is always < B, so the extra
  // comparison bit only exists in the shifted trial value t below.
  logic [len-1:0]  pr, pr_next;
  logic [len-1:0]  s, s_next;
  logic [len-1:0]  b_reg, b_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [len-1:0]  q_reg, q_next;
  logic [len-1:0]  r_reg, r_next;
  logic            ovf_reg, ovf_next;
  logic            done_reg, done_next;
  logic [len:0]    t;
  logic            qbit;

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pr       <= '0;
      s        <= '0;
      b_reg    <= '0;
      cnt      <= '0;
      q_reg    <= '0;
      r_reg    <= '0;
      ovf_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      state    <= state_next;
      pr       <= pr_next;
      s        <= s_next;
      b_reg    <= b_next;
      cnt      <= cnt_next;
      q_reg    <= q_next;
      r_reg    <= r_next;
      ovf_reg  <= ovf_next;
      done_reg <= done_next;
    end
  end

  // Next-state, iteration step and result capture.
  always_comb begin
    state_next = state;
    pr_next    = pr;
    s_next     = s;
    b_next     = b_reg;
    cnt_next   = cnt;
    q_next     = q_reg;
    r_next     = r_reg;
    ovf_next   = ovf_reg;
    done_next  = 1'b0;
    t          = {pr, s[len-1]};
    qbit       = (t >= {1'b0, b_reg});

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          b_next = bus.B;
          if (bus.A[2*len-1:len] >= bus.B) begin
            state_next = OVF;
          end else begin
            pr_next    = bus.A[2*len-1:len];
            s_next     = bus.A[len-1:0];
            cnt_next   = CW'(len);
            state_next = CALC;
          end
        end
      end
      CALC: begin
        pr_next  = qbit ? len'(t - {1'b0, b_reg}) : t[len-1:0];
        s_next   = {s[len-2:0], qbit};
        cnt_next = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          q_next     = s_next;
          r_next     = pr_next;
          ovf_next   = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      OVF: begin
        q_next     = '1;
        r_next     = '0;
        ovf_next   = 1'b1;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_reg;
  assign bus.Q    = q_reg;
  assign bus.R    = r_reg;
  assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, handshake corner
// sequences and a randomised sweep against a reference division.
module tb_seq_divider;
  localparam int len = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  seq_divider_if #(.len(len)) bus ();

  seq_divider #(.len(len)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        o;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle (or in its done cycle). Returns the
  // result and the number of edges from acceptance to done.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic o, output int lat);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = 16'($urandom);
    bus.B     = 8'($urandom);
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    q = bus.Q;
    r = bus.R;
    o = bus.ovf;
  endtask

  vec_t        vecs[9];
  logic [7:0]  q, r;
  logic        o;
  int          lat;
  int          dones;

  initial begin
    vecs[0] = '{16'd1000,  8'd7,   8'd142, 8'd6,   1'b0, 8};
    vecs[1] = '{16'd65024, 8'd255, 8'd254, 8'd254, 1'b0, 8};
    vecs[2] = '{16'd0,     8'd1,   8'd0,   8'd0,   1'b0, 8};
    vecs[3] = '{16'h0500,  8'd5,   8'hFF,  8'd0,   1'b1, 1};
    vecs[4] = '{16'h1234,  8'd0,   8'hFF,  8'd0,   1'b1, 1};
    vecs[5] = '{16'd255,   8'd16,  8'd15,  8'd15,  1'b0, 8};
    vecs[6] = '{16'hFFFF,  8'd255, 8'hFF,  8'd0,   1'b1, 1};
    vecs[7] = '{16'h00FF,  8'd1,   8'd255, 8'd0,   1'b0, 8};
    vecs[8] = '{16'h7FFF,  8'h80,  8'd255, 8'd127, 1'b0, 8};

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_Q",    32'(bus.Q),    0);
    check("reset_R",    32'(bus.R),    0);
    check("reset_ovf",  32'(bus.ovf),  0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, q, r, o, lat);
      check($sformatf("vec%0d_Q", i),   32'(q),   32'(vecs[i].q));
      check($sformatf("vec%0d_R", i),   32'(r),   32'(vecs[i].r));
      check($sformatf("vec%0d_ovf", i), 32'(o),   32'(vecs[i].o));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 0);
      check($sformatf("vec%0d_hold_Q", i),     32'(bus.Q),    32'(vecs[i].q));
    end

    // Reset in the middle of a division: abort, clear outputs, no done.
    bus.start = 1'b1; bus.A = 16'd1000; bus.B = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_Q",    32'(bus.Q),    0);
    check("midrst_R",    32'(bus.R),    0);
    check("midrst_done", 32'(bus.done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("midrst_no_done", 32'(dones), 0);

    // Start pulsed while busy with different operands must be ignored.
    bus.start = 1'b1; bus.A = 16'd1000; bus.B = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    repeat (2) begin @(posedge clk); #1; lat++; end
    bus.start = 1'b1; bus.A = 16'h0500; bus.B = 8'd5;
    @(posedge clk); #1; lat++;
    bus.start = 1'b0;
    while (!bus.done && lat < 20) begin @(posedge clk); #1; lat++; end
    check("ignore_Q",   32'(bus.Q),   142);
    check("ignore_R",   32'(bus.R),   6);
    check("ignore_ovf", 32'(bus.ovf), 0);
    check("ignore_lat", 32'(lat),     8);

    // Back-to-back: start in the done cycle is accepted; result held meanwhile.
    do_op(16'd1000, 8'd7, q, r, o, lat);
    check("b2b_first_Q", 32'(q), 142);
    bus.start = 1'b1; bus.A = 16'd255; bus.B = 8'd16;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_busy",   32'(bus.busy), 1);
    check("b2b_hold_Q", 32'(bus.Q),    142);
    check("b2b_hold_R", 32'(bus.R),    6);
    lat = 0;
    while (!bus.done && lat < 20) begin @(posedge clk); #1; lat++; end
    check("b2b_Q",   32'(bus.Q), 15);
    check("b2b_R",   32'(bus.R), 15);
    check("b2b_lat", 32'(lat),   8);
    @(posedge clk); #1;

    // Random sweep against a reference division.
    for (int n = 0; n < 1500; n++) begin
      logic [7:0]  b, hi, lo, eq, er;
      logic        eo;
      logic [15:0] a;
      int          elat;
      b  = 8'($urandom_range(1, 255));
      lo = 8'($urandom);
      if (n % 8 == 7) hi = 8'($urandom_range(int'(b), 255));
      else            hi = 8'($urandom_range(0, int'(b) - 1));
      if (n % 97 == 0) b = 8'd0;
      a = {hi, lo};
      if (hi >= b) begin
        eq = 8'hFF; er = 8'd0; eo = 1'b1; elat = 1;
      end else begin
        eq = 8'(a / 16'(b)); er = 8'(a % 16'(b)); eo = 1'b0; elat = 8;
      end
      do_op(a, b, q, r, o, lat);
      check($sformatf("rnd%0d_result a=%0d b=%0d", n, a, b), {15'd0, o, q, r}, {15'd0, eo, eq, er});
      check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(elat));
      if (!eo)
        check($sformatf("rnd%0d_invariant", n),
              32'((int'(q) * int'(b) + int'(r) == int'(a)) && (r < b)), 1);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
